// File: rtl/genius_round_sequencer.sv
// Genius (Simon) round sequencer: LFSR colour sequence, timed playback/echo, win/lose detection.
// Optional input timeout is enabled by defining GENIUS_INPUT_TIMEOUT_EN (adds TIMEOUT_CYCLES).
module genius_round_sequencer #(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned OFF_CYCLES = 12500000,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
`ifdef GENIUS_INPUT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 150000000
`endif
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               START,
  input  logic                               BTN_VALID,
  input  logic [1:0]                         BTN_COLOR,
  output logic                               VGA_FLAG,
  output logic [1:0]                         VGA,
  output logic                               VGA_LOSE,
  output logic                               VGA_WIN,
  output logic [$clog2(MAX_LEN + 1) - 1:0]   ROUND,
  output logic                               BUSY
);

  localparam int RW    = $clog2(MAX_LEN + 1);
  localparam int DEPTH = 1 << RW;

  localparam int unsigned PHASE_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
`ifdef GENIUS_INPUT_TIMEOUT_EN
  localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > PHASE_MAX) ? TIMEOUT_CYCLES : PHASE_MAX;
`else
  localparam int unsigned TIMER_MAX = PHASE_MAX;
`endif
  // Timer only ever holds count-1, so clog2 of the largest count is enough.
  localparam int TW = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
`ifdef GENIUS_INPUT_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADD_STEP,
    S_PLAY_ON,
    S_PLAY_OFF,
    S_WAIT_INPUT,
    S_ECHO_ON,
    S_ECHO_OFF,
    S_LOSE,
    S_WIN
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   idx;
  logic [7:0]      lfsr;
  logic [1:0]      btn_q;
  logic            match_q;
  logic [1:0]      seq [DEPTH];

  logic            phase_done;
  logic            idx_last;
  logic            round_full;
  logic [1:0]      seq_at_idx;

  assign phase_done = (timer == '0);
  assign idx_last   = (idx == ROUND - RW'(1));
  assign round_full = (ROUND == RW'(MAX_LEN));
  assign seq_at_idx = seq[idx];

`ifdef GENIUS_INPUT_TIMEOUT_EN
  logic timeout_hit;
  assign timeout_hit = (timer == TIMEOUT_LAST);
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_LOSE, S_WIN: if (START) next_state = S_ADD_STEP;
      S_ADD_STEP:            next_state = S_PLAY_ON;
      S_PLAY_ON:             if (phase_done) next_state = S_PLAY_OFF;
      S_PLAY_OFF:            if (phase_done) next_state = idx_last ? S_WAIT_INPUT : S_PLAY_ON;
      S_WAIT_INPUT: begin
        if (BTN_VALID) next_state = S_ECHO_ON;
`ifdef GENIUS_INPUT_TIMEOUT_EN
        else if (timeout_hit) next_state = S_LOSE;
`endif
      end
      S_ECHO_ON:             if (phase_done) next_state = S_ECHO_OFF;
      S_ECHO_OFF: begin
        if (phase_done) begin
          if (!match_q)       next_state = S_LOSE;
          else if (!idx_last) next_state = S_WAIT_INPUT;
          else if (round_full) next_state = S_WIN;
          else                next_state = S_ADD_STEP;
        end
      end
      default:               next_state = S_IDLE;
    endcase
  end

  // Phase timer reloads on every state change; WAIT_INPUT counts up only for the timeout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timer <= '0;
    end else if (next_state != state) begin
      case (next_state)
        S_PLAY_ON, S_ECHO_ON:   timer <= ON_LOAD;
        S_PLAY_OFF, S_ECHO_OFF: timer <= OFF_LOAD;
        default:                timer <= '0;
      endcase
    end
`ifdef GENIUS_INPUT_TIMEOUT_EN
    else if (state == S_WAIT_INPUT) begin
      timer <= timer + TW'(1);
    end
`endif
    else if (!phase_done) begin
      timer <= timer - TW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ROUND   <= '0;
      idx     <= '0;
      lfsr    <= SEED_EFF;
      btn_q   <= 2'b00;
      match_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOSE, S_WIN: if (START) ROUND <= '0;
        S_ADD_STEP: begin
          ROUND <= ROUND + RW'(1);
          idx   <= '0;
          lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        S_PLAY_OFF: if (phase_done) idx <= idx_last ? '0 : idx + RW'(1);
        S_WAIT_INPUT: begin
          if (BTN_VALID) begin
            btn_q   <= BTN_COLOR;
            match_q <= (BTN_COLOR == seq_at_idx);
          end
        end
        S_ECHO_OFF: if (phase_done && match_q && !idx_last) idx <= idx + RW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the sequence store has no reset; every entry is written before it is read.
  always_ff @(posedge CLK) begin
    if (state == S_ADD_STEP) seq[ROUND] <= lfsr[1:0];
  end

  // Outputs are registered decodes of the current state, so they trail it by one cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      VGA_FLAG <= 1'b0;
      VGA      <= 2'b00;
      VGA_LOSE <= 1'b0;
      VGA_WIN  <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      VGA_FLAG <= (state == S_PLAY_ON) || (state == S_ECHO_ON);
      VGA      <= (state == S_PLAY_ON) ? seq_at_idx :
                  (state == S_ECHO_ON) ? btn_q : 2'b00;
      VGA_LOSE <= (state == S_LOSE);
      VGA_WIN  <= (state == S_WIN);
      BUSY     <= !(state inside {S_IDLE, S_WAIT_INPUT, S_LOSE, S_WIN});
    end
  end

endmodule

// File: tb/tb_genius_round_sequencer.sv
// Self-checking bench for genius_round_sequencer: transaction-level game model, random presses.
// Define GENIUS_INPUT_TIMEOUT_EN for both bench and RTL to exercise the input timeout.
module tb_genius_round_sequencer;

  localparam int         MAX_LEN = 2;
  localparam int         ON_C    = 4;
  localparam int         OFF_C   = 2;
  localparam logic [7:0] SEED    = 8'hA5;
  localparam int         RW      = $clog2(MAX_LEN + 1);

  logic          CLK = 1'b0;
  logic          RESET;
  logic          START;
  logic          BTN_VALID;
  logic [1:0]    BTN_COLOR;
  logic          VGA_FLAG;
  logic [1:0]    VGA;
  logic          VGA_LOSE;
  logic          VGA_WIN;
  logic [RW-1:0] ROUND;
  logic          BUSY;

  int vectors     = 0;
  int miscompares = 0;

  // Game model: colour list, current round, press position, held result flags.
  logic [7:0] model_lfsr;
  logic [1:0] model_seq [$];
  int         round_m;
  int         pos_m;
  bit         lose_m;
  bit         win_m;

  genius_round_sequencer #(
    .MAX_LEN(MAX_LEN),
    .ON_CYCLES(ON_C),
    .OFF_CYCLES(OFF_C),
    .LFSR_SEED(SEED)
`ifdef GENIUS_INPUT_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(10)
`endif
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .START(START),
    .BTN_VALID(BTN_VALID),
    .BTN_COLOR(BTN_COLOR),
    .VGA_FLAG(VGA_FLAG),
    .VGA(VGA),
    .VGA_LOSE(VGA_LOSE),
    .VGA_WIN(VGA_WIN),
    .ROUND(ROUND),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [5+RW:0] observed();
    return {VGA_FLAG, VGA, VGA_LOSE, VGA_WIN, BUSY, ROUND};
  endfunction

  task automatic check(input string tag, input logic [5+RW:0] obs, input logic [5+RW:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b ({flag,vga,lose,win,busy,round})", tag, obs, exp);
    end
  endtask

  task automatic sample(input string tag, input bit flag, input logic [1:0] col, input bit busy);
    @(negedge CLK);
    check(tag, observed(), {flag, col, lose_m, win_m, busy, RW'(round_m)});
  endtask

  // Append one colour taken from a Fibonacci LFSR with taps 7,5,4,3.
  task automatic model_add_step();
    model_seq.push_back(model_lfsr[1:0]);
    model_lfsr = {model_lfsr[6:0], ^(model_lfsr & 8'b1011_1000)};
    round_m++;
  endtask

  task automatic add_step_and_play();
    model_add_step();
    pos_m = 0;
    sample("add_step", 1'b0, 2'b00, 1'b1);
    foreach (model_seq[i]) begin
      for (int k = 0; k < ON_C; k++) begin
        if (k == 0 && $urandom_range(0, 1) == 1) begin
          BTN_VALID = 1'b1;
          BTN_COLOR = 2'($urandom_range(0, 3));
          START     = 1'($urandom_range(0, 1));
        end
        sample("play_on", 1'b1, model_seq[i], 1'b1);
        BTN_VALID = 1'b0;
        START     = 1'b0;
      end
      for (int k = 0; k < OFF_C; k++) sample("play_off", 1'b0, 2'b00, 1'b1);
    end
    sample("wait_entry", 1'b0, 2'b00, 1'b0);
  endtask

  task automatic start_game(input bit with_btn);
    START     = 1'b1;
    BTN_VALID = with_btn;
    BTN_COLOR = 2'($urandom_range(0, 3));
    round_m   = 0;
    model_seq.delete();
    sample("start_edge", 1'b0, 2'b00, 1'b0);
    START     = 1'b0;
    BTN_VALID = 1'b0;
    lose_m    = 1'b0;
    win_m     = 1'b0;
    add_step_and_play();
  endtask

  // outcome: 0 game continues, 1 lost, 2 won.
  task automatic press(input logic [1:0] c, input bit with_start, output int outcome);
    BTN_VALID = 1'b1;
    BTN_COLOR = c;
    START     = with_start;
    sample("press_edge", 1'b0, 2'b00, 1'b0);
    BTN_VALID = 1'b0;
    START     = 1'b0;
    for (int k = 0; k < ON_C; k++)  sample("echo_on", 1'b1, c, 1'b1);
    for (int k = 0; k < OFF_C; k++) sample("echo_off", 1'b0, 2'b00, 1'b1);
    if (c != model_seq[pos_m]) begin
      lose_m  = 1'b1;
      outcome = 1;
      sample("lose_entry", 1'b0, 2'b00, 1'b0);
    end else if (pos_m < round_m - 1) begin
      pos_m++;
      outcome = 0;
      sample("wait_next", 1'b0, 2'b00, 1'b0);
    end else if (round_m == MAX_LEN) begin
      win_m   = 1'b1;
      outcome = 2;
      sample("win_entry", 1'b0, 2'b00, 1'b0);
    end else begin
      outcome = 0;
      add_step_and_play();
    end
  endtask

  task automatic hold(input string tag, input int n);
    repeat (n) begin
      BTN_VALID = 1'b1;
      BTN_COLOR = 2'($urandom_range(0, 3));
      sample(tag, 1'b0, 2'b00, 1'b0);
      BTN_VALID = 1'b0;
    end
  endtask

  initial begin
    int         o;
    logic [1:0] c;

    RESET      = 1'b1;
    START      = 1'b0;
    BTN_VALID  = 1'b0;
    BTN_COLOR  = 2'b00;
    model_lfsr = SEED;
    round_m    = 0;
    pos_m      = 0;
    lose_m     = 1'b0;
    win_m      = 1'b0;

    repeat (2) sample("reset_hold", 1'b0, 2'b00, 1'b0);
    RESET = 1'b0;
    sample("idle", 1'b0, 2'b00, 1'b0);

    // Reset in the middle of the first lit colour acts without a clock edge.
    START = 1'b1;
    sample("start_edge", 1'b0, 2'b00, 1'b0);
    START = 1'b0;
    model_add_step();
    sample("add_step", 1'b0, 2'b00, 1'b1);
    sample("play_on", 1'b1, model_seq[0], 1'b1);
    sample("play_on", 1'b1, model_seq[0], 1'b1);
    #2 RESET = 1'b1;
    #1 check("async_reset", observed(), '0);
    @(negedge CLK);
    RESET      = 1'b0;
    model_lfsr = SEED;
    model_seq.delete();
    round_m    = 0;
    sample("after_reset", 1'b0, 2'b00, 1'b0);

    // Directed game to a win, then a restart ending in a loss.
    start_game(1'b0);
    press(model_seq[0], 1'b0, o);
    press(model_seq[0], 1'b0, o);
    press(model_seq[1], 1'b0, o);
    hold("win_hold", 3);
    start_game(1'b1);
    press(2'b11, 1'b0, o);
    hold("lose_hold", 3);

    // Random games: mostly correct presses, occasional wrong ones and simultaneous START.
    repeat (8) begin
      start_game(1'($urandom_range(0, 1)));
      o = 0;
      while (o == 0) begin
        repeat ($urandom_range(0, 3)) sample("wait_idle", 1'b0, 2'b00, 1'b0);
        c = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : model_seq[pos_m];
        press(c, 1'($urandom_range(0, 3) == 0), o);
      end
      hold("end_hold", 2);
    end

    start_game(1'b0);
`ifdef GENIUS_INPUT_TIMEOUT_EN
    repeat (9) sample("timeout_wait", 1'b0, 2'b00, 1'b0);
    lose_m = 1'b1;
    sample("timeout_lose", 1'b0, 2'b00, 1'b0);
`else
    repeat (1000) sample("no_timeout", 1'b0, 2'b00, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
